// File: rtl/dct_1d_stream.sv
// ---------------------------------------------------------------------------
// dct_1d_stream
//   Streaming 16-point 1-D DCT. Sixteen samples are collected into a buffer.
//   After the buffer is full, the block produces one coefficient per accepted
//   output beat. Each coefficient comes from 16 parallel multiplies and one
//   adder tree. The coefficients are 7-bit signed values in 1.6 format.
//
//   The sum is then scaled in this order:
//     1. optional rounding add
//     2. arithmetic right shift by FRAC
//     3. wrap or saturate to OUT_W bits
//
// Ports
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   in_valid   in_data carries a sample
//   in_ready   high only in LOAD; a sample is taken when in_valid && in_ready
//   in_data    sample x[n], n = 0..15 in order
//   out_valid  out_data holds X[out_idx]
//   out_ready  downstream accepts the coefficient
//   out_data   scaled coefficient, two's complement
//   out_idx    coefficient index k
//   out_last   high with out_valid when k = 15
//   busy       high in any state other than LOAD
// ---------------------------------------------------------------------------
module dct_1d_stream #(
    parameter int IN_W      = 11,
    parameter int IN_SIGNED = 0,
    parameter int OUT_W     = 12,
    parameter int FRAC      = 6,
    parameter int ROUND     = 0,
    parameter int SAT       = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [3:0]       out_idx,
    output logic             out_last,
    output logic             busy
);

    localparam int ACC_W  = IN_W + 12;
    localparam int RND_SH = (FRAC > 0) ? (FRAC - 1) : 0;
    localparam logic signed [ACC_W-1:0] RND_K =
        ((ROUND != 0) && (FRAC > 0)) ? (ACC_W'(1'b1) << RND_SH) : {ACC_W{1'b0}};
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Magnitude table C_p, p = 1..15. Index 0 and 16 are never addressed.
    function automatic logic signed [6:0] coef_mag(input logic [4:0] p);
        logic signed [6:0] c;
        case (p)
            5'd1:    c = 7'sd23;
            5'd2:    c = 7'sd22;
            5'd3:    c = 7'sd22;
            5'd4:    c = 7'sd21;
            5'd5:    c = 7'sd20;
            5'd6:    c = 7'sd19;
            5'd7:    c = 7'sd17;
            5'd8:    c = 7'sd16;
            5'd9:    c = 7'sd14;
            5'd10:   c = 7'sd13;
            5'd11:   c = 7'sd11;
            5'd12:   c = 7'sd9;
            5'd13:   c = 7'sd7;
            5'd14:   c = 7'sd4;
            5'd15:   c = 7'sd2;
            default: c = 7'sd0;
        endcase
        return c;
    endfunction

    // c(k,n): the phase p = k*(2n+1) mod 64 folds onto C_1..C_15 with a
    // quadrant-dependent sign. The 6-bit product truncation is the mod 64.
    function automatic logic signed [6:0] coef(input logic [3:0] k, input logic [3:0] n);
        logic [5:0]        p;
        logic signed [6:0] c;
        p = 6'({2'b00, k} * {1'b0, n, 1'b1});
        if (k == 4'd0) begin
            c = 7'sd16;
        end else if (p <= 6'd16) begin
            c = coef_mag(p[4:0]);
        end else if (p <= 6'd32) begin
            c = -coef_mag(5'(6'd32 - p));
        end else if (p <= 6'd48) begin
            c = -coef_mag(5'(p - 6'd32));
        end else begin
            c = coef_mag(5'(6'd0 - p));
        end
        return c;
    endfunction

    state_t                  state_q;
    logic [3:0]              ld_cnt_q;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_data_q;
    logic [3:0]              out_idx_q;
    logic                    out_last_q;
    logic [IN_W-1:0]         buf_q [16];

    logic                    load_fire_s;
    logic [3:0]              k_sel_s;
    logic signed [ACC_W-1:0] samp_s [16];
    logic signed [ACC_W-1:0] prod_s [16];
    logic signed [ACC_W-1:0] s1_s [8];
    logic signed [ACC_W-1:0] s2_s [4];
    logic signed [ACC_W-1:0] s3_s [2];
    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] rnd_s;
    logic signed [ACC_W-1:0] shf_s;
    logic [OUT_W-1:0]        out_data_d;

    assign load_fire_s = rstn && in_valid && in_ready_q;

    // Choose the coefficient index for the next out_data update.
    // CALC builds X[0]. OUT builds X[out_idx+1].
    always_comb begin
        k_sel_s = 4'd0;
        if (state_q == ST_CALC) begin
            k_sel_s = 4'd0;
        end else begin
            k_sel_s = out_idx_q + 4'd1;
        end
    end

    // Extend each sample (zero or sign) and form the 16 parallel products.
    always_comb begin
        for (int n = 0; n < 16; n++) begin
            if (IN_SIGNED != 0) begin
                samp_s[n] = ACC_W'($signed(buf_q[n]));
            end else begin
                samp_s[n] = ACC_W'(buf_q[n]);
            end
            prod_s[n] = samp_s[n] * ACC_W'(coef(k_sel_s, 4'(n)));
        end
    end

    // Balanced adder tree reducing the 16 products to one accumulator.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            s1_s[i] = prod_s[2*i] + prod_s[2*i+1];
        end
        for (int i = 0; i < 4; i++) begin
            s2_s[i] = s1_s[2*i] + s1_s[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            s3_s[i] = s2_s[2*i] + s2_s[2*i+1];
        end
        acc_s = s3_s[0] + s3_s[1];
    end

    // Scale the sum: rounding add, then arithmetic shift, then wrap or clamp.
    always_comb begin
        rnd_s = acc_s + RND_K;
        shf_s = rnd_s >>> FRAC;
        if ((SAT != 0) && (shf_s > MAX_V)) begin
            out_data_d = MAX_V[OUT_W-1:0];
        end else if ((SAT != 0) && (shf_s < MIN_V)) begin
            out_data_d = MIN_V[OUT_W-1:0];
        end else begin
            out_data_d = shf_s[OUT_W-1:0];
        end
    end

    // Write the sample buffer only on accepted handshakes. It is frozen
    // outside LOAD.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            buf_q[ld_cnt_q] <= in_data;
        end
    end

    // Control FSM with registered handshake and output signals.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_LOAD;
            ld_cnt_q    <= 4'd0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            out_idx_q   <= 4'd0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_fire_s) begin
                        ld_cnt_q <= ld_cnt_q + 4'd1;
                        if (ld_cnt_q == 4'd15) begin
                            state_q    <= ST_CALC;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    state_q     <= ST_OUT;
                    out_valid_q <= 1'b1;
                    out_data_q  <= out_data_d;
                    out_idx_q   <= 4'd0;
                    out_last_q  <= 1'b0;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        if (out_idx_q == 4'd15) begin
                            state_q     <= ST_LOAD;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            ld_cnt_q    <= 4'd0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            out_data_q <= out_data_d;
                            out_idx_q  <= out_idx_q + 4'd1;
                            out_last_q <= (out_idx_q == 4'd14);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_LOAD;
                    ld_cnt_q    <= 4'd0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_1d_stream.sv
// ---------------------------------------------------------------------------
// tb_dct_1d_stream
//   Four instances share the same stimulus:
//     A  default parameters
//     B  signed input with rounding
//     C  8-bit saturating output
//     D  8-bit wrapping output
//   Expected coefficients for every instance are pushed into queues when a
//   frame is issued. A monitor pops the queues on each output handshake.
//   The monitor also applies random out_ready backpressure.
// ---------------------------------------------------------------------------
module tb_dct_1d_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        in_valid;
    logic        out_ready;
    logic [10:0] in_data;

    logic [3:0]  in_ready_v;
    logic [3:0]  busy_v;
    logic [3:0]  out_valid_v;
    logic [3:0]  out_last_v;
    logic [3:0]  idx_v [4];
    logic [11:0] data_a;
    logic [11:0] data_b;
    logic [7:0]  data_c;
    logic [7:0]  data_d;

    int vectors = 0;
    int errors  = 0;
    int qa[$];
    int qb[$];
    int qc[$];
    int qd[$];
    int qk[$];
    int ctab [16] = '{16, 23, 22, 22, 21, 20, 19, 17, 16, 14, 13, 11, 9, 7, 4, 2};

    dct_1d_stream u_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_data(data_a), .out_idx(idx_v[0]), .out_last(out_last_v[0]), .busy(busy_v[0])
    );

    dct_1d_stream #(.IN_SIGNED(1), .ROUND(1)) u_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_data(data_b), .out_idx(idx_v[1]), .out_last(out_last_v[1]), .busy(busy_v[1])
    );

    dct_1d_stream #(.OUT_W(8), .SAT(1)) u_c (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_data(in_data), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_data(data_c), .out_idx(idx_v[2]), .out_last(out_last_v[2]), .busy(busy_v[2])
    );

    dct_1d_stream #(.OUT_W(8), .SAT(0)) u_d (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_v[3]),
        .in_data(in_data), .out_valid(out_valid_v[3]), .out_ready(out_ready),
        .out_data(data_d), .out_idx(idx_v[3]), .out_last(out_last_v[3]), .busy(busy_v[3])
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap8(input int v);
        logic signed [7:0] t;
        t = v[7:0];
        return int'(t);
    endfunction

    // Frame kinds:
    //   0  all samples = 100
    //   1  impulse x[0] = 64
    //   2  x[0] = 1984 (-64 in 11-bit two's complement)
    //   3  x[0] = 2
    //   4  all samples = 2047
    function automatic logic [10:0] sample_val(input int kind, input int n);
        case (kind)
            0:       return 11'd100;
            1:       return (n == 0) ? 11'd64 : 11'd0;
            2:       return (n == 0) ? 11'd1984 : 11'd0;
            3:       return (n == 0) ? 11'd2 : 11'd0;
            default: return 11'd2047;
        endcase
    endfunction

    // Hand-derived coefficients for each frame kind and instance.
    task automatic push_frame(input int kind);
        for (int k = 0; k < 16; k++) begin
            int a;
            int b;
            int c;
            int d;
            case (kind)
                0: begin
                    // 100*16*16 >> 6 = 400. 400 clamps to 127 and wraps
                    // to -112 in 8 bits.
                    a = (k == 0) ? 400 : 0;
                    b = a;
                    c = (k == 0) ? 127 : 0;
                    d = (k == 0) ? -112 : 0;
                end
                1: begin
                    a = ctab[k];
                    b = a;
                    c = a;
                    d = a;
                end
                2: begin
                    // Unsigned: 1984*c/64 = 31*c. Signed: -64 gives -c.
                    a = 31 * ctab[k];
                    b = -ctab[k];
                    c = (a > 127) ? 127 : a;
                    d = wrap8(a);
                end
                3: begin
                    // Truncation gives 0. Rounding gives 1 where 2*c + 32 >= 64,
                    // i.e. c >= 16, i.e. k <= 8.
                    a = 0;
                    b = (k <= 8) ? 1 : 0;
                    c = 0;
                    d = 0;
                end
                default: begin
                    // 2047*256 >> 6 = 8188, which wraps to -4.
                    // Signed input is -1: (-256 + 32) >>> 6 = -4.
                    a = (k == 0) ? -4 : 0;
                    b = a;
                    c = (k == 0) ? 127 : 0;
                    d = a;
                end
            endcase
            qa.push_back(a);
            qb.push_back(b);
            qc.push_back(c);
            qd.push_back(d);
            qk.push_back(k);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_sample(input logic [10:0] d);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200 && !got; t++) begin
            got = in_ready_v[0];
            @(negedge clk);
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed low for sample %0d", d);
        end
    endtask

    task automatic send_frame(input int kind);
        bit done;
        push_frame(kind);
        for (int n = 0; n < 16; n++) begin
            send_sample(sample_val(kind, n));
        end
        // Keep offering a junk sample while busy; it must never be taken.
        in_data = 11'h5A5;
        chk("calc_busy", int'(busy_v[0]), 1);
        chk("calc_no_valid", int'(out_valid_v[0]), 0);
        @(negedge clk);
        chk("first_valid_latency", int'(out_valid_v[0]), 1);
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            if (busy_v[0] == 1'b0) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            vectors++;
            errors++;
            $display("FAIL frame_timeout: busy still %0d after budget", busy_v[0]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready_v[0]), 1);
        chk({tag, "_busy"}, int'(busy_v[0]), 0);
        chk({tag, "_out_valid"}, int'(out_valid_v[0]), 0);
        chk({tag, "_out_idx"}, int'(idx_v[0]), 0);
        chk({tag, "_out_data"}, int'($signed(data_a)), 0);
        chk({tag, "_out_last"}, int'(out_last_v[0]), 0);
    endtask

    // Monitor: drives random backpressure, checks stall stability and pops
    // the expected queues on each output handshake.
    initial begin
        bit stalled;
        int snap_data;
        int snap_idx;
        int snap_last;
        int k;
        stalled   = 1'b0;
        snap_data = 0;
        snap_idx  = 0;
        snap_last = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (rstn !== 1'b1) begin
                stalled = 1'b0;
            end else begin
                if (busy_v[0] && in_ready_v[0]) begin
                    vectors++;
                    errors++;
                    $display("FAIL ready_while_busy: in_ready %0d busy %0d", in_ready_v[0], busy_v[0]);
                end
                if (out_valid_v[0] === 1'b1) begin
                    if (stalled) begin
                        chk("stall_hold_data", int'($signed(data_a)), snap_data);
                        chk("stall_hold_idx", int'(idx_v[0]), snap_idx);
                        chk("stall_hold_last", int'(out_last_v[0]), snap_last);
                    end
                    if (out_ready) begin
                        stalled = 1'b0;
                        if (qk.size() == 0) begin
                            vectors++;
                            errors++;
                            $display("FAIL unexpected_output: idx %0d, expected none", idx_v[0]);
                        end else begin
                            k = qk.pop_front();
                            chk($sformatf("XA[%0d]", k), int'($signed(data_a)), qa.pop_front());
                            chk($sformatf("XB[%0d]", k), int'($signed(data_b)), qb.pop_front());
                            chk($sformatf("XC[%0d]", k), int'($signed(data_c)), qc.pop_front());
                            chk($sformatf("XD[%0d]", k), int'($signed(data_d)), qd.pop_front());
                            chk("out_idx", int'(idx_v[0]), k);
                            chk("out_last", int'(out_last_v[0]), (k == 15) ? 1 : 0);
                        end
                    end else begin
                        stalled   = 1'b1;
                        snap_data = int'($signed(data_a));
                        snap_idx  = int'(idx_v[0]);
                        snap_last = int'(out_last_v[0]);
                    end
                end else begin
                    if (stalled) begin
                        vectors++;
                        errors++;
                        $display("FAIL stall_valid_drop: out_valid %0d, expected 1", out_valid_v[0]);
                    end
                    stalled = 1'b0;
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = 11'd0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rstn = 1'b1;

        send_frame(0);
        send_frame(1);
        send_frame(2);
        send_frame(3);
        send_frame(4);

        // Abort a partial frame with a reset, then expect a clean impulse frame.
        for (int n = 0; n < 7; n++) begin
            send_sample(11'd500);
        end
        in_valid = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("abort_reset");
        rstn = 1'b1;
        send_frame(1);

        repeat (3) @(negedge clk);
        chk("leftover_expected", qk.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dct_1d_stream.md
DCT_1D_STREAM -- requirements
Module: dct_1d_stream

Interface
REQ-001 Parameter IN_W, 11, input sample width in bits.
REQ-002 Parameter IN_SIGNED, 0, input sample encoding: 0 = unsigned (row pass), 1 = two's complement (column pass).
REQ-003 Parameter OUT_W, 12, output coefficient width in bits, two's complement.
REQ-004 Parameter FRAC, 6, right-shift applied to the accumulator; matches the 1.6 coefficient format.
REQ-005 Parameter ROUND, 0, scaling mode: 0 = truncate (arithmetic shift), 1 = add 2^(FRAC-1) before the shift.
REQ-006 Parameter SAT, 0, overflow mode: 0 = keep the low OUT_W bits (wrap), 1 = clamp to the OUT_W two's-complement range.
REQ-007 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-008 Port rstn, input, 1, reset: synchronous, active-low.
REQ-009 Port in_valid, input, 1, in_data is valid.
REQ-010 Port in_ready, output, 1, the block accepts a sample this cycle.
REQ-011 Port in_data, input, IN_W, sample x[n], delivered in order n = 0..15.
REQ-012 Port out_valid, output, 1, out_data holds coefficient X[out_idx].
REQ-013 Port out_ready, input, 1, the downstream block accepts the coefficient.
REQ-014 Port out_data, output, OUT_W, scaled coefficient.
REQ-015 Port out_idx, output, 4, coefficient index k.
REQ-016 Port out_last, output, 1, high with out_valid when k = 15.
REQ-017 Port busy, output, 1, high in any state other than LOAD.

Function
REQ-018 Accept a sample on each edge where in_valid && in_ready; a 4-bit load counter addresses a 16-entry sample buffer.
REQ-019 States: LOAD (in_ready = 1), CALC (one cycle, first coefficient computed), OUT (out_valid = 1); in_ready SHALL be 0 outside LOAD.
REQ-020 LOAD -> CALC on the edge accepting sample 15; CALC -> OUT on the next edge, with out_data = X[0] and out_idx = 0.
REQ-021 In OUT, on each edge where out_ready = 1: if out_idx < 15, register X[out_idx+1] and increment out_idx; if out_idx = 15, go to LOAD, clear out_valid and clear the load counter.
REQ-022 In OUT with out_ready = 0, out_data, out_idx and out_last SHALL hold stable.
REQ-023 Latency: the first coefficient is valid 2 edges after the 16th input handshake; a frame needs at least 16 + 1 + 16 cycles.
REQ-024 Computation: X[k] = sum over n = 0..15 of x[n]*c(k,n), using 16 parallel products and one adder tree per cycle.
REQ-025 The accumulator SHALL be IN_W+12 bits signed; an unsigned input SHALL be zero-extended.
REQ-026 Coefficient table (7-bit signed, 1.6 format): C1..C15 = 23,22,22,21,20,19,17,16,14,13,11,9,7,4,2; DC coefficient c(0,n) = 16.
REQ-027 For k > 0, with p = (k*(2n+1)) mod 64: p <= 16 -> +C_p; 17..32 -> -C_(32-p); 33..48 -> -C_(p-32); 49..63 -> +C_(64-p).
REQ-028 Scaling order: optional rounding add, then arithmetic shift right by FRAC, then wrap or saturate to OUT_W.
REQ-029 Input handshakes are ignored while busy = 1; the sample buffer SHALL NOT change outside LOAD.

Reset
REQ-030 When rstn = 0 at an edge: state = LOAD, load counter = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, busy = 0, and in_ready = 1 from the following cycle.
REQ-031 A reset in any state SHALL discard the partial frame; the next accepted sample is x[0].

Verification
REQ-032 Defaults, all 16 samples = 100 -> X[0] = 400 and X[1..15] = 0, with out_last set only on k = 15.
REQ-033 Impulse x[0] = 64, others 0 -> X[0..15] = 16,23,22,22,21,20,19,17,16,14,13,11,9,7,4,2; with IN_SIGNED = 1 and x[0] = -64, every coefficient is negated.
REQ-034 x[0] = 2, others 0: ROUND = 0 -> X[0] = 0 and X[1] = 0; ROUND = 1 -> X[0] = 1 and X[1] = 1.
REQ-035 OUT_W = 8, all samples = 2047: SAT = 1 -> X[0] = 127; SAT = 0 -> X[0] = -4; X[1..15] = 0 in both modes.
REQ-036 Random out_ready backpressure plus in_valid held high while busy -> no coefficient lost or duplicated, outputs stable while stalled, and no input accepted while busy = 1.
REQ-037 rstn pulsed low after 7 accepted samples, then a full impulse frame -> the outputs of REQ-033, with no stale data from the aborted frame.
